// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: per-channel glitch filters feed a Gray-code step
// decoder that drives a signed, wrap-around position counter.
module quad_decoder #(
    parameter int COUNT_W    = 16,
    parameter int FILTER_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               clear,
    output logic [COUNT_W-1:0] count,
    output logic               dir,
    output logic               step,
    output logic               err,
    output logic               err_sticky,
    output logic               ready
);
    localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [4:0] INIT_LAST = 5'(FILTER_LEN);

    typedef enum logic {INIT, RUN} state_t;

    state_t     state;
    logic       filt_a;
    logic       filt_b;
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;
    logic [1:0] prev;
    logic [4:0] init_timer;
    logic [1:0] cur;
    logic       fwd;
    logic       rev;
    logic       bad;

    assign cur = {filt_a, filt_b};

    // A level is accepted only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_a <= 1'b0;
            filt_b <= 1'b0;
            cnt_a  <= '0;
            cnt_b  <= '0;
        end else begin
            if (enc_a == filt_a) begin
                cnt_a <= '0;
            end else if (cnt_a == FILT_LAST) begin
                filt_a <= enc_a;
                cnt_a  <= '0;
            end else begin
                cnt_a <= cnt_a + 4'd1;
            end

            if (enc_b == filt_b) begin
                cnt_b <= '0;
            end else if (cnt_b == FILT_LAST) begin
                filt_b <= enc_b;
                cnt_b  <= '0;
            end else begin
                cnt_b <= cnt_b + 4'd1;
            end
        end
    end

    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        bad = 1'b0;
        case ({prev, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: bad = 1'b1;
            default: ;
        endcase
    end

    // INIT lets the filters settle on the resting encoder level before any
    // transition is decoded, so a non-zero resting state raises no error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            init_timer <= '0;
            prev       <= 2'b00;
            count      <= '0;
            dir        <= 1'b1;
            step       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            ready      <= 1'b0;
        end else begin
            step <= 1'b0;
            err  <= 1'b0;
            prev <= cur;
            case (state)
                INIT: begin
                    if (init_timer == INIT_LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        init_timer <= init_timer + 5'd1;
                    end
                end
                RUN: begin
                    if (fwd) begin
                        step  <= 1'b1;
                        dir   <= 1'b1;
                        count <= count + COUNT_W'(1);
                    end else if (rev) begin
                        step  <= 1'b1;
                        dir   <= 1'b0;
                        count <= count - COUNT_W'(1);
                    end else if (bad) begin
                        err        <= 1'b1;
                        err_sticky <= 1'b1;
                    end
                end
                default: ;
            endcase
            // clear wins over a same-edge step or error; the err pulse itself survives
            if (clear) begin
                count      <= '0;
                err_sticky <= 1'b0;
            end
        end
    end
endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter COUNT_W, default 16: width of the position counter.
REQ-002 Parameter FILTER_LEN, default 4: consecutive identical samples needed to accept a level change on A or B (legal range 1..15).
REQ-003 clk  input  1  sole clock; all logic samples on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enc_a  input  1  encoder channel A, already synchronized into clk by the upstream synchronizer stage.
REQ-006 enc_b  input  1  encoder channel B, already synchronized likewise.
REQ-007 clear  input  1  synchronous request; zeroes count and err_sticky.
REQ-008 count  output  COUNT_W  signed position, modulo 2^COUNT_W.
REQ-009 dir  output  1  direction of the last accepted step; 1 = forward, 0 = reverse.
REQ-010 step  output  1  one-cycle pulse on every accepted step.
REQ-011 err  output  1  one-cycle pulse on every illegal transition.
REQ-012 err_sticky  output  1  set by err, held until clear or reset.
REQ-013 ready  output  1  high while the decoder is in RUN.

Function
REQ-014 Each channel SHALL have a glitch filter with a filtered level filt_x and a stability counter cnt_x.
REQ-015 Filter rule per edge: raw == filt_x -> cnt_x <= 0; raw != filt_x and cnt_x < FILTER_LEN-1 -> cnt_x increments; raw != filt_x and cnt_x == FILTER_LEN-1 -> filt_x <= raw, cnt_x <= 0.
REQ-016 A pulse shorter than FILTER_LEN samples SHALL never reach filt_x. With FILTER_LEN=1, filt_x follows raw with one edge of delay.
REQ-017 The decoder SHALL keep prev = {filt_a, filt_b} from the previous edge and compare it with the current {filt_a, filt_b}.
REQ-018 Forward sequence (dir=1, count+1): 00->01->11->10->00.
REQ-019 Reverse sequence (dir=0, count-1): 00->10->11->01->00.
REQ-020 If both filtered bits change on the same edge, the decoder SHALL flag an illegal transition: err pulses, err_sticky sets, and count, dir and step are unchanged.
REQ-021 If the filtered state is unchanged, the decoder SHALL hold count and dir, and step and err SHALL stay 0.
REQ-022 Latency: if the new raw level is first sampled at edge 1 and held, filt_x changes at edge FILTER_LEN and count/step/dir update at edge FILTER_LEN+1.
REQ-023 count SHALL wrap modularly: max-positive +1 -> min-negative, and 0 -1 -> all-ones; no saturation and no flag.
REQ-024 State machine states: INIT, RUN.
REQ-025 INIT: an init timer counts FILTER_LEN+1 edges while prev tracks the filtered state; no step/err is produced; after that the machine enters RUN and ready=1.
REQ-026 RUN SHALL be left only by reset.
REQ-027 clear SHALL set count <= 0 and err_sticky <= 0 on the same edge.
REQ-028 clear SHALL take priority over a simultaneous step (count = 0) and over a simultaneous err (err still pulses, err_sticky = 0).
REQ-029 clear SHALL NOT affect dir, the filters, prev or the state.
REQ-030 step and err SHALL never be high on the same cycle.

Reset
REQ-031 While rst_n is low, the block SHALL force: count=0, dir=1, step=0, err=0, err_sticky=0, ready=0, filt_a=filt_b=0, cnt_a=cnt_b=0, prev=00, state=INIT, init timer=0.
REQ-032 Reset asserted mid-operation SHALL abort immediately, with no final step or err.
REQ-033 After release, the first FILTER_LEN+1 edges SHALL run INIT, so an encoder resting at 11 yields no spurious err.

Verification
REQ-034 Reset with A=B=1 held, FILTER_LEN=4 -> ready rises at edge 5 after release; err_sticky=0; count=0.
REQ-035 In RUN, drive 8 forward Gray steps, each held 10 cycles -> count=8, dir=1, exactly 8 step pulses; each pulse occurs 5 edges after its input change.
REQ-036 3-cycle pulse on A with FILTER_LEN=4 -> no step, no err, count unchanged; a 4-cycle pulse -> count +1 then -1, ending at 0.
REQ-037 Toggle A and B together from 00 to 11 -> single err pulse, err_sticky=1, count unchanged; then clear -> err_sticky=0.
REQ-038 COUNT_W=4, count=7, one forward step -> count=-8 (4'b1000); from 0, one reverse step -> 4'b1111.
REQ-039 clear asserted on the same edge as a step pulse -> count=0 and dir updated; rst_n pulsed low mid-sequence -> all outputs return to their reset values asynchronously.
